cpu_reg_file_sb: RTL and testbench

Parametrised integer register file for the CPU pipeline, successor to the basic two-read/one-write file. Adds the following:
- asynchronous reset of all registers
- configurable data width and register count
- optional same-cycle write-to-read bypass
- per-register scoreboard (busy bits) so the decode stage can detect RAW hazards on operands whose producers have not yet written back
- pipeline flush

Sits between decode (reads, reservations) and write-back (writes).

---
 rtl/cpu_reg_file_sb.sv | 85 ++++++++
 tb/tb_cpu_reg_file_sb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reg_file_sb.sv
// Two-read/one-write integer register file with optional write-to-read bypass
// and a per-register busy scoreboard for RAW hazard detection at decode.
module cpu_reg_file_sb #(
   parameter int   XLEN           = 32,
   parameter logic MORE_REGISTERS = 1'b1,
   parameter logic BYPASS         = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      addr_rd1,
   input  logic [4:0]      addr_rd2,
   output logic [XLEN-1:0] data_rd1,
   output logic [XLEN-1:0] data_rd2,
   output logic            busy_rd1,
   output logic            busy_rd2,
   input  logic [4:0]      addr_wr,
   input  logic [XLEN-1:0] data_wr,
   input  logic            wr,
   input  logic [4:0]      addr_rsv,
   input  logic            rsv,
   input  logic            flush
);

   localparam int NREG = MORE_REGISTERS ? 31 : 15;

   logic [XLEN-1:0] regs_q [1:NREG];
   logic [NREG:1]   busy_q;
   logic [NREG:1]   busy_d;

   // x0 and out-of-range addresses never match any loop index, so they read
   // as zero / not busy and their writes and reservations fall through.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no latch is inferred.
      data_rd1 = '0;
      data_rd2 = '0;
      busy_rd1 = 1'b0;
      busy_rd2 = 1'b0;
      for (int i = 1; i <= NREG; i++) begin
         if (addr_rd1 == 5'(i)) begin
            data_rd1 = (BYPASS && wr && addr_wr == addr_rd1) ? data_wr : regs_q[i];
            busy_rd1 = busy_q[i];
         end
         if (addr_rd2 == 5'(i)) begin
            data_rd2 = (BYPASS && wr && addr_wr == addr_rd2) ? data_wr : regs_q[i];
            busy_rd2 = busy_q[i];
         end
      end
   end

   // A new reservation outranks a retiring write to the same register:
   // the newer producer still owes a result.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         for (int i = 1; i <= NREG; i++) begin
            if (rsv && addr_rsv == 5'(i)) begin
               busy_d[i] = 1'b1;
            end else if (wr && addr_wr == 5'(i)) begin
               busy_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the whole array is reset here, which rules out a RAM macro; a flop array is intended.
         for (int i = 1; i <= NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates on the same edge order-independent.
         for (int i = 1; i <= NREG; i++) begin
            if (wr && addr_wr == 5'(i)) begin
               regs_q[i] <= data_wr;
            end
         end
         busy_q <= busy_d;
      end
   end

endmodule

// File: tb/tb_cpu_reg_file_sb.sv
// Directed bench for cpu_reg_file_sb: three instances share stimulus so the
// default, no-bypass and 15-register variants are checked side by side.
module tb_cpu_reg_file_sb;

   localparam int XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic [4:0]      addr_rd1, addr_rd2, addr_wr, addr_rsv;
   logic [XLEN-1:0] data_wr;
   logic            wr, rsv, flush;

   logic [XLEN-1:0] full_rd1, full_rd2, nb_rd1, nb_rd2, rve_rd1, rve_rd2;
   logic            full_b1, full_b2, nb_b1, nb_b2, rve_b1, rve_b2;

   int tests  = 0;
   int failed = 0;

   cpu_reg_file_sb #(.XLEN(XLEN), .MORE_REGISTERS(1'b1), .BYPASS(1'b1)) u_full (
      .clk(clk), .rst_n(rst_n), .addr_rd1(addr_rd1), .addr_rd2(addr_rd2),
      .data_rd1(full_rd1), .data_rd2(full_rd2), .busy_rd1(full_b1), .busy_rd2(full_b2),
      .addr_wr(addr_wr), .data_wr(data_wr), .wr(wr), .addr_rsv(addr_rsv), .rsv(rsv),
      .flush(flush));

   cpu_reg_file_sb #(.XLEN(XLEN), .MORE_REGISTERS(1'b1), .BYPASS(1'b0)) u_nb (
      .clk(clk), .rst_n(rst_n), .addr_rd1(addr_rd1), .addr_rd2(addr_rd2),
      .data_rd1(nb_rd1), .data_rd2(nb_rd2), .busy_rd1(nb_b1), .busy_rd2(nb_b2),
      .addr_wr(addr_wr), .data_wr(data_wr), .wr(wr), .addr_rsv(addr_rsv), .rsv(rsv),
      .flush(flush));

   cpu_reg_file_sb #(.XLEN(XLEN), .MORE_REGISTERS(1'b0), .BYPASS(1'b1)) u_rve (
      .clk(clk), .rst_n(rst_n), .addr_rd1(addr_rd1), .addr_rd2(addr_rd2),
      .data_rd1(rve_rd1), .data_rd2(rve_rd2), .busy_rd1(rve_b1), .busy_rd2(rve_b2),
      .addr_wr(addr_wr), .data_wr(data_wr), .wr(wr), .addr_rsv(addr_rsv), .rsv(rsv),
      .flush(flush));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr = 1'b0; rsv = 1'b0; flush = 1'b0;
      addr_wr = '0; addr_rsv = '0; data_wr = '0;
   endtask

   task automatic cmp_data(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic cmp_bit(input string name, input logic got, input logic exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      wr = 1'b1; addr_wr = 5'd5; data_wr = 32'hDEADBEEF;
      step();
      idle();
      rsv = 1'b1; addr_rsv = 5'd7;
      step();
      idle();
      addr_rd1 = 5'd5; addr_rd2 = 5'd7;
      #1;
      cmp_data("reset_pre_x5", full_rd1, 32'hDEADBEEF);
      cmp_bit("reset_pre_busy_x7", full_b2, 1'b1);
      rst_n = 1'b0;
      #1;
      cmp_data("reset_async_x5", full_rd1, 32'h0);
      cmp_bit("reset_async_busy_x7", full_b2, 1'b0);
      cmp_data("reset_async_x5_rve", rve_rd1, 32'h0);
      cmp_bit("reset_async_busy_x7_nb", nb_b2, 1'b0);
      rst_n = 1'b1;
      step();
      cmp_bit("reset_stays_clear_x7", full_b2, 1'b0);
   endtask

   task automatic test_write_x0();
      wr = 1'b1; addr_wr = 5'd3; data_wr = 32'h12345678;
      step();
      wr = 1'b1; addr_wr = 5'd0; data_wr = 32'hFFFFFFFF;
      rsv = 1'b1; addr_rsv = 5'd0;
      addr_rd1 = 5'd3; addr_rd2 = 5'd0;
      #1;
      cmp_data("x3_written", full_rd1, 32'h12345678);
      cmp_data("x0_no_bypass", full_rd2, 32'h0);
      step();
      idle();
      #1;
      cmp_data("x0_reads_zero", full_rd2, 32'h0);
      cmp_bit("x0_busy_zero", full_b2, 1'b0);
      cmp_data("x3_after_x0_write", full_rd1, 32'h12345678);
   endtask

   task automatic test_bypass();
      wr = 1'b1; addr_wr = 5'd9; data_wr = 32'h11;
      step();
      wr = 1'b1; addr_wr = 5'd9; data_wr = 32'hA5A5A5A5;
      addr_rd1 = 5'd9; addr_rd2 = 5'd3;
      #1;
      cmp_data("bypass_same_cycle", full_rd1, 32'hA5A5A5A5);
      cmp_data("nobypass_old_value", nb_rd1, 32'h11);
      cmp_data("bypass_other_port_unaffected", full_rd2, 32'h12345678);
      step();
      idle();
      #1;
      cmp_data("nobypass_next_cycle", nb_rd1, 32'hA5A5A5A5);
      cmp_data("bypass_next_cycle", full_rd1, 32'hA5A5A5A5);
   endtask

   task automatic test_scoreboard();
      rsv = 1'b1; addr_rsv = 5'd4;
      addr_rd1 = 5'd4; addr_rd2 = 5'd13;
      #1;
      cmp_bit("rsv_not_yet_busy", full_b1, 1'b0);
      step();
      idle();
      #1;
      cmp_bit("rsv_busy_next", full_b1, 1'b1);
      wr = 1'b1; addr_wr = 5'd4; data_wr = 32'h40;
      #1;
      cmp_bit("wr_busy_still_set", full_b1, 1'b1);
      step();
      idle();
      #1;
      cmp_bit("wr_clears_busy", full_b1, 1'b0);
      cmp_data("wr_x4_data", full_rd1, 32'h40);
      rsv = 1'b1; addr_rsv = 5'd4;
      wr = 1'b1; addr_wr = 5'd4; data_wr = 32'h44;
      step();
      idle();
      #1;
      cmp_bit("rsv_wr_same_keeps_busy", full_b1, 1'b1);
      cmp_data("rsv_wr_same_data", full_rd1, 32'h44);
      rsv = 1'b1; addr_rsv = 5'd4;
      step();
      idle();
      #1;
      cmp_bit("repeat_rsv_busy", full_b1, 1'b1);
      rsv = 1'b1; addr_rsv = 5'd13;
      wr = 1'b1; addr_wr = 5'd4; data_wr = 32'h4;
      step();
      idle();
      #1;
      cmp_bit("split_wr_clears_x4", full_b1, 1'b0);
      cmp_bit("split_rsv_sets_x13", full_b2, 1'b1);
      cmp_data("split_wr_x4_data", full_rd1, 32'h4);
   endtask

   task automatic test_flush();
      rsv = 1'b1; addr_rsv = 5'd2;
      step();
      addr_rsv = 5'd6;
      step();
      addr_rsv = 5'd10;
      step();
      idle();
      addr_rd1 = 5'd2; addr_rd2 = 5'd10;
      #1;
      cmp_bit("flush_pre_x2", full_b1, 1'b1);
      cmp_bit("flush_pre_x10", full_b2, 1'b1);
      flush = 1'b1;
      rsv = 1'b1; addr_rsv = 5'd11;
      wr = 1'b1; addr_wr = 5'd12; data_wr = 32'h99;
      step();
      idle();
      addr_rd1 = 5'd2; addr_rd2 = 5'd6;
      #1;
      cmp_bit("flush_x2", full_b1, 1'b0);
      cmp_bit("flush_x6", full_b2, 1'b0);
      addr_rd1 = 5'd10; addr_rd2 = 5'd11;
      #1;
      cmp_bit("flush_x10", full_b1, 1'b0);
      cmp_bit("flush_drops_rsv_x11", full_b2, 1'b0);
      addr_rd1 = 5'd12; addr_rd2 = 5'd13;
      #1;
      cmp_data("flush_keeps_wr_x12", full_rd1, 32'h99);
      cmp_bit("flush_x13", full_b2, 1'b0);
   endtask

   task automatic test_small_regs();
      wr = 1'b1; addr_wr = 5'd20; data_wr = 32'h55;
      rsv = 1'b1; addr_rsv = 5'd20;
      step();
      idle();
      addr_rd1 = 5'd20; addr_rd2 = 5'd20;
      #1;
      cmp_data("rve_x20_reads_zero", rve_rd1, 32'h0);
      cmp_bit("rve_x20_not_busy", rve_b2, 1'b0);
      cmp_data("full_x20_written", full_rd1, 32'h55);
      cmp_bit("full_x20_busy", full_b2, 1'b1);
      wr = 1'b1; addr_wr = 5'd15; data_wr = 32'h77;
      step();
      wr = 1'b1; addr_wr = 5'd16; data_wr = 32'h16;
      step();
      wr = 1'b1; addr_wr = 5'd31; data_wr = 32'h31;
      step();
      idle();
      addr_rd1 = 5'd15; addr_rd2 = 5'd16;
      #1;
      cmp_data("rve_x15_top", rve_rd1, 32'h77);
      cmp_data("rve_x16_ignored", rve_rd2, 32'h0);
      cmp_data("full_x16", full_rd2, 32'h16);
      addr_rd1 = 5'd31;
      #1;
      cmp_data("full_x31_top", full_rd1, 32'h31);
      cmp_data("rve_x31_ignored", rve_rd1, 32'h0);
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 3; i++) begin
         wr = 1'b1; addr_wr = 5'(i + 20); data_wr = 32'hC000_0000 + 32'(i);
         step();
      end
      idle();
      addr_rd1 = 5'd21; addr_rd2 = 5'd23;
      #1;
      cmp_data("b2b_x21", full_rd1, 32'hC000_0001);
      cmp_data("b2b_x23", nb_rd2, 32'hC000_0003);
      addr_rd1 = 5'd22;
      #1;
      cmp_data("b2b_x22", full_rd1, 32'hC000_0002);
   endtask

   initial begin
      rst_n = 1'b0;
      addr_rd1 = '0; addr_rd2 = '0;
      idle();
      #1;
      cmp_data("por_rd1_zero", full_rd1, 32'h0);
      cmp_bit("por_busy_zero", full_b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      test_reset();
      test_write_x0();
      test_bypass();
      test_scoreboard();
      test_flush();
      test_small_regs();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
